// File: rtl/irrigacao_sequenciador.sv
// irrigacao_sequenciador
// Irrigation-cycle sequencer: fill the tank, irrigate by sprinkler or drip,
// then clean the lines. Drives the one-hot mode indications consumed by the
// downstream actuator clock selector.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   start        : cycle request, level-sampled in IDLE only
//   umidade_ok   : soil moisture sufficient
//   modo         : 1 = sprinkler, 0 = drip (sampled when entering irrigation)
//   tanque_cheio : tank-full sensor
//   tanque_vazio : tank-empty sensor
//   ack_erro     : operator fault acknowledge
//   start_fill   : one-cycle pulse on the first ENCHER cycle
//   state        : fill pump enable (ENCHER)
//   Aspersao     : sprinkler phase
//   Gotejamento  : drip phase
//   Limpeza      : line cleaning phase
//   ERRO         : fault state
//   estado       : current state code
//   done         : one-cycle pulse on the first IDLE cycle after LIMPEZA
//
// All outputs are registered decodes of the state register, so an input
// sampled at edge N shows up on the outputs after edge N+1.
module irrigacao_sequenciador #(
  parameter int FILL_TIMEOUT = 200,
  parameter int ASP_CYCLES   = 100,
  parameter int GOT_CYCLES   = 150,
  parameter int LIMP_CYCLES  = 50,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       umidade_ok,
  input  logic       modo,
  input  logic       tanque_cheio,
  input  logic       tanque_vazio,
  input  logic       ack_erro,
  output logic       start_fill,
  output logic       state,
  output logic       Aspersao,
  output logic       Gotejamento,
  output logic       Limpeza,
  output logic       ERRO,
  output logic [2:0] estado,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ENCHER      = 3'd1,
    S_ASPERSAO    = 3'd2,
    S_GOTEJAMENTO = 3'd3,
    S_LIMPEZA     = 3'd4,
    S_ERRO        = 3'd5
  } state_t;

  // Terminal counter values: a phase of duration D exits when counter == D-1.
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ASP_LAST  = CNT_W'(ASP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GOT_LAST  = CNT_W'(GOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMP_LAST = CNT_W'(LIMP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              from_limp_q;   // state_q just entered IDLE from LIMPEZA

  logic              start_fill_q, state_out_q, asp_q, got_q, limp_q, erro_q;
  logic [2:0]        estado_q;
  logic              done_q;

  state_t            irrig_sel;

  always_comb begin
    irrig_sel = modo ? S_ASPERSAO : S_GOTEJAMENTO;
    state_d   = state_q;

    case (state_q)
      S_IDLE: begin
        if (start && !umidade_ok) begin
          state_d = tanque_cheio ? irrig_sel : S_ENCHER;
        end
      end
      S_ENCHER: begin
        // A full tank wins over a timeout on the same cycle.
        if (tanque_cheio) begin
          state_d = irrig_sel;
        end else if (cnt_q == FILL_LAST) begin
          state_d = S_ERRO;
        end
      end
      S_ASPERSAO: begin
        if (tanque_vazio) begin
          state_d = S_ERRO;
        end else if (umidade_ok || cnt_q == ASP_LAST) begin
          state_d = S_LIMPEZA;
        end
      end
      S_GOTEJAMENTO: begin
        if (tanque_vazio) begin
          state_d = S_ERRO;
        end else if (umidade_ok || cnt_q == GOT_LAST) begin
          state_d = S_LIMPEZA;
        end
      end
      S_LIMPEZA: begin
        if (cnt_q == LIMP_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_ERRO: begin
        // Acknowledge is only honoured once the tank is no longer empty.
        if (ack_erro && !tanque_vazio) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;   // codes 6 and 7
    endcase

    // Counter restarts on every state change; it may wrap harmlessly in the
    // untimed states because no comparison is made there.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      from_limp_q  <= 1'b0;
      start_fill_q <= 1'b0;
      state_out_q  <= 1'b0;
      asp_q        <= 1'b0;
      got_q        <= 1'b0;
      limp_q       <= 1'b0;
      erro_q       <= 1'b0;
      estado_q     <= 3'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      from_limp_q  <= (state_q == S_LIMPEZA) && (state_d == S_IDLE);
      // Counter is zero only on the first cycle of a phase.
      start_fill_q <= (state_q == S_ENCHER) && (cnt_q == '0);
      state_out_q  <= (state_q == S_ENCHER);
      asp_q        <= (state_q == S_ASPERSAO);
      got_q        <= (state_q == S_GOTEJAMENTO);
      limp_q       <= (state_q == S_LIMPEZA);
      erro_q       <= (state_q == S_ERRO);
      estado_q     <= state_q;
      done_q       <= from_limp_q;
    end
  end

  assign start_fill  = start_fill_q;
  assign state       = state_out_q;
  assign Aspersao    = asp_q;
  assign Gotejamento = got_q;
  assign Limpeza     = limp_q;
  assign ERRO        = erro_q;
  assign estado      = estado_q;
  assign done        = done_q;

endmodule

// File: tb/tb_irrigacao_sequenciador.sv
// Scoreboard bench for irrigacao_sequenciador. A phase-level reference model
// predicts the output vector for each clock edge and queues it; a monitor
// compares every edge's outputs against the queue head.
module tb_irrigacao_sequenciador;

  localparam int FILL = 8;
  localparam int ASP  = 4;
  localparam int GOT  = 5;
  localparam int LIMP = 2;

  // Phase numbers double as the state codes shown on estado.
  localparam int P_IDLE = 0, P_FILL = 1, P_ASP = 2, P_GOT = 3, P_LIMP = 4, P_ERR = 5;

  logic       clk = 1'b0;
  logic       reset, start, umidade_ok, modo, tanque_cheio, tanque_vazio, ack_erro;
  logic       start_fill, state, Aspersao, Gotejamento, Limpeza, ERRO, done;
  logic [2:0] estado;

  always #5 clk = ~clk;

  irrigacao_sequenciador #(
    .FILL_TIMEOUT(FILL), .ASP_CYCLES(ASP), .GOT_CYCLES(GOT),
    .LIMP_CYCLES(LIMP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .umidade_ok(umidade_ok),
    .modo(modo), .tanque_cheio(tanque_cheio), .tanque_vazio(tanque_vazio),
    .ack_erro(ack_erro), .start_fill(start_fill), .state(state),
    .Aspersao(Aspersao), .Gotejamento(Gotejamento), .Limpeza(Limpeza),
    .ERRO(ERRO), .estado(estado), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];
  bit stim_done = 0;

  // Reference model: current phase, cycles spent in it, and the phase it
  // was entered from (-1 after reset).
  int ph = P_IDLE, el = 0, came = -1;

  function automatic int next_phase(input int p, input int e, input logic st, um, md,
                                    ch, vz, ak);
    int irr;
    irr = md ? P_ASP : P_GOT;
    case (p)
      P_IDLE: return (st && !um) ? (ch ? irr : P_FILL) : P_IDLE;
      P_FILL: begin
        if (ch) return irr;
        if (e == FILL - 1) return P_ERR;
        return P_FILL;
      end
      P_ASP, P_GOT: begin
        if (vz) return P_ERR;
        if (um) return P_LIMP;
        if (e == ((p == P_ASP) ? ASP : GOT) - 1) return P_LIMP;
        return p;
      end
      P_LIMP: return (e == LIMP - 1) ? P_IDLE : P_LIMP;
      P_ERR:  return (ak && !vz) ? P_IDLE : P_ERR;
      default: return P_IDLE;
    endcase
  endfunction

  // Vector: {start_fill, state, Aspersao, Gotejamento, Limpeza, ERRO, estado, done}
  function automatic logic [9:0] model_outputs();
    logic [9:0] v;
    logic [2:0] code;
    code = 3'(ph);
    v = {ph == P_FILL && el == 0, ph == P_FILL, ph == P_ASP, ph == P_GOT,
         ph == P_LIMP, ph == P_ERR, code, ph == P_IDLE && came == P_LIMP && el == 0};
    return v;
  endfunction

  task automatic cycle(input logic st, um, md, ch, vz, ak, rs);
    int nx;
    @(negedge clk);
    start = st; umidade_ok = um; modo = md; tanque_cheio = ch;
    tanque_vazio = vz; ack_erro = ak; reset = rs;
    exp_q.push_back(rs ? 10'b0 : model_outputs());
    if (rs) begin
      ph = P_IDLE; el = 0; came = -1;
    end else begin
      nx = next_phase(ph, el, st, um, md, ch, vz, ak);
      if (nx != ph) begin
        came = ph; ph = nx; el = 0;
      end else begin
        el++;
      end
    end
  endtask

  task automatic idle(input int n, input logic md, ch);
    for (int i = 0; i < n; i++) cycle(0, 0, md, ch, 0, 0, 0);
  endtask

  // Monitor: one comparison of the whole vector plus a one-hot check per edge.
  initial begin
    logic [9:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {start_fill, state, Aspersao, Gotejamento, Limpeza, ERRO, estado, done};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got=%b required=%b (sf,st,asp,got,limp,erro,estado,done)",
                   $time, got, e);
        end
        n_checks++;
        if ($countones({state, Aspersao, Gotejamento, Limpeza, ERRO}) > 1) begin
          n_fail++;
          $display("FAIL onehot t=%0t got=%b required at most one bit set", $time,
                   {state, Aspersao, Gotejamento, Limpeza, ERRO});
        end
      end
    end
  end

  initial begin
    {reset, start, umidade_ok, modo, tanque_cheio, tanque_vazio, ack_erro} = '0;
    reset = 1'b1;

    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(2, 0, 0);

    // Full sprinkler run, then a run reset in its second irrigation cycle.
    cycle(1, 0, 1, 1, 0, 0, 0);
    idle(9, 1, 1);
    cycle(1, 0, 1, 1, 0, 0, 0);
    idle(2, 1, 1);
    cycle(0, 0, 1, 1, 0, 0, 1);
    idle(4, 1, 1);

    // Fill for three cycles, then drip.
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);
    idle(12, 0, 1);

    // Fill timeout, blocked acknowledge, then accepted acknowledge.
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(11, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle(3, 0, 0);

    // Early stop on moisture, then empty tank beating moisture.
    cycle(1, 0, 1, 1, 0, 0, 0);
    idle(1, 1, 1);
    cycle(0, 1, 1, 1, 0, 0, 0);
    idle(5, 1, 1);
    cycle(1, 0, 1, 1, 0, 0, 0);
    idle(1, 1, 1);
    cycle(0, 1, 1, 1, 1, 0, 0);
    idle(3, 1, 1);
    cycle(0, 0, 1, 1, 0, 1, 0);
    idle(2, 1, 1);

    // Moisture already sufficient: start has no effect.
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 1, 0, 0, 0);

    // Back-to-back cycles with start held high.
    for (int i = 0; i < 20; i++) cycle(1, 0, 1, 1, 0, 0, 0);
    idle(8, 1, 1);

    // Mode toggled during sprinkler irrigation.
    cycle(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, i[0], 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0,
            $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
            $urandom_range(31, 0) == 0, $urandom_range(3, 0) == 0,
            $urandom_range(63, 0) == 0);
    end
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=no completion required=completion");
    $fatal(1, "bench timeout");
  end

endmodule
